// File: rtl/ag_tcu_bhf_fmul_seq.sv
// ag_tcu_bhf_fmul_seq
// Initiator/collector around an external fixed-latency, enable-stalled
// bf16/fp16 multiplier. Operands go straight through to the multiplier. A
// valid/tag chain runs in lockstep with the multiplier's internal registers
// and marks which tail results are real ops. Results are caught in an output
// FIFO. The whole multiplier pipe is frozen only when a real result reaches
// the tail and the FIFO cannot take it.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   valid_in/ready_in             upstream op handshake (ready_in == mul_enable)
//   a_in, b_in, frm_in, tag_in    op operands, rounding mode, user tag
//   valid_out/ready_out           downstream result handshake
//   y_out, fflags_out, tag_out    result, {NV,DZ,OF,UF,NX}, tag
//   mul_enable                    multiplier pipe advance
//   mul_a, mul_b, mul_frm         to multiplier (combinational pass-through)
//   mul_y, mul_fflags             from multiplier tail
//
// Optional build macro AG_TCU_FMUL_FFLAGS_ACC_EN adds fflags_clr/fflags_acc:
// a sticky OR of the flags of every popped result.

module ag_tcu_bhf_fmul_seq #(
    parameter int EXPW        = 8,
    parameter int SIGW        = 8,
    parameter int MUL_LATENCY = 1,
    parameter int RND_LATENCY = 1,
    parameter int TAGW        = 4,
    parameter int OBUF_DEPTH  = 4,
    localparam int FECW       = EXPW + SIGW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    output logic            ready_in,
    input  logic [FECW-1:0] a_in,
    input  logic [FECW-1:0] b_in,
    input  logic [2:0]      frm_in,
    input  logic [TAGW-1:0] tag_in,
    output logic            valid_out,
    input  logic            ready_out,
    output logic [FECW-1:0] y_out,
    output logic [4:0]      fflags_out,
    output logic [TAGW-1:0] tag_out,
`ifdef AG_TCU_FMUL_FFLAGS_ACC_EN
    input  logic            fflags_clr,
    output logic [4:0]      fflags_acc,
`endif
    output logic            mul_enable,
    output logic [FECW-1:0] mul_a,
    output logic [FECW-1:0] mul_b,
    output logic [2:0]      mul_frm,
    input  logic [FECW-1:0] mul_y,
    input  logic [4:0]      mul_fflags
);

    localparam int LAT = MUL_LATENCY + RND_LATENCY;
    localparam int AW  = $clog2(OBUF_DEPTH);
    localparam int EW  = FECW + 5 + TAGW;
    localparam logic [AW:0] FULL_CNT = OBUF_DEPTH[AW:0];

    // In-flight tracking, one bit/tag per multiplier register stage
    logic [LAT-1:0]           vld;
    logic [LAT-1:0][TAGW-1:0] tg;

    // Output FIFO
    logic [EW-1:0] mem [OBUF_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic tail_valid, fifo_full, push, pop;

    assign mul_a   = a_in;
    assign mul_b   = b_in;
    assign mul_frm = frm_in;

    assign tail_valid = vld[LAT-1];
    assign fifo_full  = (count == FULL_CNT);
    assign valid_out  = (count != '0);
    assign pop        = valid_out & ready_out;

    // A pop while full frees the slot this same cycle, so it does not stall.
    // Bubbles at the tail never stall either: they are simply dropped.
    assign mul_enable = ~reset & ~(tail_valid & fifo_full & ~pop);
    assign ready_in   = mul_enable;
    assign push       = tail_valid & mul_enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            tg  <= '0;
        end else if (mul_enable) begin
            vld[0] <= valid_in;
            tg[0]  <= tag_in;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                tg[i]  <= tg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {mul_y, mul_fflags, tg[LAT-1]};
    end

    assign {y_out, fflags_out, tag_out} = mem[rd_ptr];

`ifdef AG_TCU_FMUL_FFLAGS_ACC_EN
    // Clear first, then OR: a pop in the same cycle as a clear is kept.
    always_ff @(posedge clk) begin
        if (reset)
            fflags_acc <= '0;
        else
            fflags_acc <= (fflags_clr ? 5'b0 : fflags_acc) | (pop ? fflags_out : 5'b0);
    end
`endif

endmodule

// File: tb/tb_ag_tcu_bhf_fmul_seq.sv
module tb_ag_tcu_bhf_fmul_seq;

    localparam int FECW = 16;
    localparam int TAGW = 4;
    localparam int LAT  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_in, ready_in;
    logic [FECW-1:0] a_in, b_in;
    logic [2:0]      frm_in;
    logic [TAGW-1:0] tag_in;
    logic            valid_out, ready_out;
    logic [FECW-1:0] y_out;
    logic [4:0]      fflags_out;
    logic [TAGW-1:0] tag_out;
    logic            mul_enable;
    logic [FECW-1:0] mul_a, mul_b, mul_y;
    logic [2:0]      mul_frm;
    logic [4:0]      mul_fflags;
`ifdef AG_TCU_FMUL_FFLAGS_ACC_EN
    logic            fflags_clr;
    logic [4:0]      fflags_acc;
`endif

    ag_tcu_bhf_fmul_seq dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .ready_in(ready_in),
        .a_in(a_in), .b_in(b_in), .frm_in(frm_in), .tag_in(tag_in),
        .valid_out(valid_out), .ready_out(ready_out),
        .y_out(y_out), .fflags_out(fflags_out), .tag_out(tag_out),
`ifdef AG_TCU_FMUL_FFLAGS_ACC_EN
        .fflags_clr(fflags_clr), .fflags_acc(fflags_acc),
`endif
        .mul_enable(mul_enable), .mul_a(mul_a), .mul_b(mul_b), .mul_frm(mul_frm),
        .mul_y(mul_y), .mul_fflags(mul_fflags)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier result: the few bf16 cases used by the directed
    // tests return their true IEEE results; anything else returns an
    // arbitrary but deterministic pattern so routing/order can be checked.
    function automatic logic [20:0] mock_mul(input logic [15:0] a, input logic [15:0] b,
                                             input logic [2:0] frm);
        if (a == 16'h3FC0 && b == 16'h4000) return {16'h4040, 5'b00000};
        if (a == 16'h7F80 && b == 16'h0000) return {16'h7FC0, 5'b10000};
        if (a == 16'h7F00 && b == 16'h7F00) return {16'h7F80, 5'b00101};
        if (a == 16'h3F81 && b == 16'h3F81) return {16'h3F82, 5'b00001};
        return {a ^ {b[7:0], b[15:8]} ^ {13'd0, frm}, a[4:0] ^ b[9:5]};
    endfunction

    // External multiplier model: LAT registers that advance only on mul_enable
    logic [20:0] mstage [LAT];
    always @(posedge clk) begin
        if (mul_enable) begin
            mstage[0] <= mock_mul(mul_a, mul_b, mul_frm);
            for (int i = 1; i < LAT; i++) mstage[i] <= mstage[i-1];
        end
    end
    assign mul_y      = mstage[LAT-1][20:5];
    assign mul_fflags = mstage[LAT-1][4:0];

    typedef struct packed {
        logic [15:0] y;
        logic [4:0]  f;
        logic [3:0]  tag;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops one expected result per DUT pop; also checks
    // that outputs hold while stalled by the consumer.
    logic        hold_chk = 1'b0;
    logic [24:0] prev_out;
    always @(negedge clk) begin
        if (reset) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("hold_valid", {31'd0, valid_out}, 32'd1);
                chk("hold_data", {7'd0, y_out, fflags_out, tag_out}, {7'd0, prev_out});
            end
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {31'd0, valid_out}, 32'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("y_out", {16'd0, y_out}, {16'd0, e.y});
                    chk("fflags_out", {27'd0, fflags_out}, {27'd0, e.f});
                    chk("tag_out", {28'd0, tag_out}, {28'd0, e.tag});
                end
            end
            hold_chk = valid_out && !ready_out;
            prev_out = {y_out, fflags_out, tag_out};
        end
    end

    // Sample at negedge: record an accepted op into the scoreboard
    task automatic half();
        @(negedge clk);
        if (!reset && valid_in && ready_in) begin
            exp_q.push_back({mock_mul(a_in, b_in, frm_in), tag_in});
            n_acc++;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] frm, input logic [3:0] tag);
        valid_in = v; a_in = a; b_in = b; frm_in = frm; tag_in = tag;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            half();
            if (exp_q.size() == 0 && !valid_out) done = 1;
            adv();
        end
        chk("drain_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        set_op(1'b0, 16'h0, 16'h0, 3'd0, 4'd0);
        ready_out = 1'b1;
`ifdef AG_TCU_FMUL_FFLAGS_ACC_EN
        fflags_clr = 1'b0;
`endif
        adv(); adv();
        half();
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_ready_in", {31'd0, ready_in}, 32'd0);
        chk("rst_mul_enable", {31'd0, mul_enable}, 32'd0);
        adv();
        reset = 1'b0;

        // Single op: accepted in cycle 0, result visible in cycle LAT+1
        set_op(1'b1, 16'h3FC0, 16'h4000, 3'd0, 4'd3);
        half();
        chk("first_ready_in", {31'd0, ready_in}, 32'd1);
        adv();
        valid_in = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            half();
            chk("lat_valid_out", {31'd0, valid_out}, (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) begin
                chk("lat_y_out", {16'd0, y_out}, 32'h4040);
                chk("lat_tag_out", {28'd0, tag_out}, 32'd3);
            end
            adv();
        end
        drain();

        // Streaming: 8 back-to-back ops, outputs on cycles 3..10
        for (int k = 0; k < 12; k++) begin
            set_op(k < 8, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 4)), 4'(k));
            half();
            if (k < 8) chk("stream_ready_in", {31'd0, ready_in}, 32'd1);
            chk("stream_valid_out", {31'd0, valid_out}, (k >= 3 && k <= 10) ? 32'd1 : 32'd0);
            adv();
        end
        drain();

        // Backpressure: 4 FIFO + LAT pipe = 6 ops, then stall
        n_acc = 0;
        ready_out = 1'b0;
        for (int k = 0; k < 12; k++) begin
            set_op(1'b1, 16'($urandom), 16'($urandom), 3'd1, 4'(k));
            half();
            adv();
        end
        half();
        chk("bp_accepted", n_acc, 32'd6);
        chk("bp_ready_in", {31'd0, ready_in}, 32'd0);
        chk("bp_mul_enable", {31'd0, mul_enable}, 32'd0);
        adv();
        ready_out = 1'b1;
        tag_in = 4'hC;
        half();
        chk("bp_pop_enable", {31'd0, mul_enable}, 32'd1);
        chk("bp_pop_ready_in", {31'd0, ready_in}, 32'd1);
        adv();
        ready_out = 1'b0;
        valid_in = 1'b0;
        half();
        chk("bp_one_more", n_acc, 32'd7);
        adv();
        drain();

        // Exceptions: inf*0 -> qNaN/NV, huge*huge -> inf/OF|NX
        set_op(1'b1, 16'h7F80, 16'h0000, 3'd0, 4'd1);
        half(); adv();
        set_op(1'b1, 16'h7F00, 16'h7F00, 3'd0, 4'd2);
        half(); adv();
        drain();

        // Reset mid-flight: in-flight ops vanish
        for (int k = 0; k < 3; k++) begin
            set_op(1'b1, 16'($urandom), 16'($urandom), 3'd0, 4'(k));
            if (k == 2) begin
                reset = 1'b1;
                exp_q.delete();
            end
            half();
            adv();
        end
        reset = 1'b0;
        valid_in = 1'b0;
        for (int k = 3; k <= 10; k++) begin
            half();
            chk("post_rst_valid_out", {31'd0, valid_out}, 32'd0);
            adv();
        end
        set_op(1'b1, 16'h1234, 16'h5678, 3'd2, 4'd9);
        half(); adv();
        valid_in = 1'b0;
        half(); adv();
        half(); adv();
        half();
        chk("post_rst_lat_valid", {31'd0, valid_out}, 32'd1);
        chk("post_rst_lat_tag", {28'd0, tag_out}, 32'd9);
        adv();
        drain();

`ifdef AG_TCU_FMUL_FFLAGS_ACC_EN
        fflags_clr = 1'b1;
        half(); adv();
        fflags_clr = 1'b0;
        set_op(1'b1, 16'h7F80, 16'h0000, 3'd0, 4'd1);
        half(); adv();
        set_op(1'b1, 16'h7F00, 16'h7F00, 3'd0, 4'd2);
        half(); adv();
        drain();
        half();
        chk("acc_nv_of_nx", {27'd0, fflags_acc}, 32'h15);
        adv();
        fflags_clr = 1'b1;
        half(); adv();
        fflags_clr = 1'b0;
        half();
        chk("acc_cleared", {27'd0, fflags_acc}, 32'd0);
        adv();
        // Seed acc with NV, then clear in the same cycle an NX result pops
        set_op(1'b1, 16'h7F80, 16'h0000, 3'd0, 4'd4);
        half(); adv();
        drain();
        ready_out = 1'b0;
        set_op(1'b1, 16'h3F81, 16'h3F81, 3'd0, 4'd5);
        half(); adv();
        valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin half(); adv(); end
        ready_out = 1'b1;
        fflags_clr = 1'b1;
        half(); adv();
        fflags_clr = 1'b0;
        half();
        chk("acc_clr_with_pop", {27'd0, fflags_acc}, 32'd1);
        adv();
        drain();
`endif

        // Randomized traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            set_op($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
                   3'($urandom_range(0, 4)), 4'($urandom));
            ready_out = $urandom_range(0, 9) < 6;
            half();
            adv();
        end
        drain();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
